pipe_controller: RTL and testbench

- Decode/hazard controller for the 5-stage 19-bit-instruction pipeline; drives the datapath control inputs from the ID-stage instruction (IF_ID_instruction) and the C/Z flags.
- Tracks in-flight register and flag writes in a scoreboard, stalls on RAW hazards (the datapath has no forwarding), and resolves branches, jumps, calls and returns in ID with a one-slot flush.

---
 rtl/pipe_controller.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Decode and hazard controller for the 5-stage, 19-bit-instruction pipeline.
// Stalls on RAW register/flag hazards and resolves control flow in ID.
module pipe_controller #(
  parameter int unsigned SB_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] IF_ID_instruction,
  input  logic        C,
  input  logic        Z,
  output logic        mem_write,
  output logic        reg_write,
  output logic        push,
  output logic        pop,
  output logic        alu_use_carry,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_mux,
  output logic [1:0]  reg_write_mux,
  output logic        alu_in_mux,
  output logic        reg_B_mux,
  output logic        select_c,
  output logic        select_z,
  output logic        write_c,
  output logic        write_z,
  output logic        stall,
  output logic        flush
);

  typedef enum logic [3:0] {
    CL_NOP, CL_R, CL_I, CL_LW, CL_SW, CL_SH, CL_BR, CL_JMP, CL_JSB, CL_RET
  } cls_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       wc;
    logic       wz;
  } sb_entry_t;

  sb_entry_t  sb [SB_DEPTH];
  cls_e       cls;
  logic [2:0] rd, rs, rt, src_b;
  logic [2:0] d_op;
  logic [1:0] d_rwm;
  logic       d_mw, d_rw, d_uc, d_ai, d_rb, d_sc, d_sz, d_wc, d_wz;
  logic       use_a, use_b, raw_haz, flag_haz, stall_i, taken;

  assign rd = IF_ID_instruction[13:11];
  assign rs = IF_ID_instruction[10:8];
  assign rt = IF_ID_instruction[7:5];

  always_comb begin
    cls = CL_NOP;
    if (IF_ID_instruction != '0) begin
      casez (IF_ID_instruction[18:13])
        6'b00????: cls = CL_R;
        6'b01????: cls = CL_I;
        6'b100???: cls = CL_LW;
        6'b101???: cls = CL_SW;
        6'b110???: cls = CL_SH;
        6'b1110??: cls = CL_BR;
        6'b111100: cls = CL_JMP;
        6'b111101: cls = CL_JSB;
        6'b111110: cls = CL_RET;
        default:   cls = CL_NOP;
      endcase
    end
  end

  always_comb begin
    d_op  = '0;
    d_rwm = '0;
    d_mw  = 1'b0;
    d_rw  = 1'b0;
    d_uc  = 1'b0;
    d_ai  = 1'b0;
    d_rb  = 1'b0;
    d_sc  = 1'b0;
    d_sz  = 1'b0;
    d_wc  = 1'b0;
    d_wz  = 1'b0;
    use_a = 1'b0;
    use_b = 1'b0;
    src_b = rt;
    case (cls)
      CL_R, CL_I: begin
        d_op  = IF_ID_instruction[16:14];
        d_rw  = 1'b1;
        d_ai  = (cls == CL_I);
        d_uc  = IF_ID_instruction[14] & ~IF_ID_instruction[16];
        d_wc  = ~IF_ID_instruction[16];
        d_wz  = 1'b1;
        use_a = 1'b1;
        use_b = (cls == CL_R);
      end
      CL_LW: begin
        d_ai  = 1'b1;
        d_rwm = 2'b10;
        d_rw  = 1'b1;
        use_a = 1'b1;
      end
      CL_SW: begin
        d_ai  = 1'b1;
        d_rb  = 1'b1;
        d_mw  = 1'b1;
        use_a = 1'b1;
        use_b = 1'b1;
        src_b = rd;
      end
      CL_SH: begin
        d_rwm = 2'b01;
        d_rw  = 1'b1;
        d_sc  = 1'b1;
        d_sz  = 1'b1;
        d_wc  = 1'b1;
        d_wz  = 1'b1;
        use_a = 1'b1;
      end
      default: ;
    endcase
  end

  // Every entry is checked: no forwarding, and MEM_WB writeback lands only after this cycle.
  always_comb begin
    raw_haz = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb[i].valid && ((use_a && sb[i].rd == rs) || (use_b && sb[i].rd == src_b)))
        raw_haz = 1'b1;
    end
    flag_haz = (cls == CL_BR) &&
               (IF_ID_instruction[14] ? sb[0].wc : sb[0].wz);
    stall_i  = raw_haz | flag_haz;
  end

  always_comb begin
    case (IF_ID_instruction[14:13])
      2'b00:   taken = Z;
      2'b01:   taken = ~Z;
      2'b10:   taken = C;
      default: taken = ~C;
    endcase
  end

  always_comb begin
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    alu_use_carry = 1'b0;
    alu_op        = '0;
    pc_mux        = '0;
    reg_write_mux = '0;
    alu_in_mux    = 1'b0;
    reg_B_mux     = 1'b0;
    select_c      = 1'b0;
    select_z      = 1'b0;
    write_c       = 1'b0;
    write_z       = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    if (!reset) begin
      alu_use_carry = d_uc;
      alu_op        = d_op;
      reg_write_mux = d_rwm;
      alu_in_mux    = d_ai;
      reg_B_mux     = d_rb;
      select_c      = d_sc;
      select_z      = d_sz;
      stall         = stall_i;
      if (!stall_i) begin
        mem_write = d_mw;
        reg_write = d_rw;
        write_c   = d_wc;
        write_z   = d_wz;
        case (cls)
          CL_BR: begin
            if (taken) begin
              pc_mux = 2'b01;
              flush  = 1'b1;
            end
          end
          CL_JMP: begin
            pc_mux = 2'b10;
            flush  = 1'b1;
          end
          CL_JSB: begin
            pc_mux = 2'b10;
            push   = 1'b1;
            flush  = 1'b1;
          end
          CL_RET: begin
            pc_mux = 2'b11;
            pop    = 1'b1;
            flush  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= '{valid: d_rw & ~stall_i, rd: rd, wc: d_wc & ~stall_i, wz: d_wz & ~stall_i};
      for (int unsigned i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: a cycle-age hazard model predicts
// every output vector, which is queued at drive time and compared each cycle.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] IF_ID_instruction;
  logic        C, Z;
  logic        mem_write, reg_write, push, pop, alu_use_carry;
  logic [2:0]  alu_op;
  logic [1:0]  pc_mux, reg_write_mux;
  logic        alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z, stall, flush;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wr [8];
  int last_c, last_z;
  logic [19:0] exp_q [$];

  pipe_controller #(.SB_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .IF_ID_instruction(IF_ID_instruction), .C(C), .Z(Z),
    .mem_write(mem_write), .reg_write(reg_write), .push(push), .pop(pop),
    .alu_use_carry(alu_use_carry), .alu_op(alu_op), .pc_mux(pc_mux),
    .reg_write_mux(reg_write_mux), .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux),
    .select_c(select_c), .select_z(select_z), .write_c(write_c), .write_z(write_z),
    .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [18:0] r_ins(input logic [1:0] cl, input logic [2:0] op,
                                        input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
    return {cl, op, d, s, t, 5'b0};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) last_wr[i] = -100;
    last_c = -100;
    last_z = -100;
  endtask

  task automatic predict(input logic [18:0] ins, input logic c, input logic z, input logic rst,
                         output logic [19:0] e, output logic wr, output logic [2:0] wrd,
                         output logic fc, output logic fz);
    logic mw, rw, pu, po, uc, ai, rb, sc, sz, wc, wz, st, fl, br, ha, hb, tk;
    logic [2:0] op, b;
    logic [1:0] pm, rwm;
    {mw, rw, pu, po, uc, ai, rb, sc, sz, wc, wz, st, fl, br, ha, hb, tk} = '0;
    op = '0; pm = '0; rwm = '0; b = ins[7:5];
    if (ins == 19'd0) begin
    end else if (ins[18] == 1'b0) begin
      op = ins[16:14]; rw = 1; ai = ins[17];
      uc = (op == 3'd1) || (op == 3'd3);
      wc = (op <= 3'd3); wz = 1; ha = 1; hb = ~ins[17];
    end else if (ins[18:16] == 3'b100) begin
      ai = 1; rwm = 2'b10; rw = 1; ha = 1;
    end else if (ins[18:16] == 3'b101) begin
      ai = 1; rb = 1; mw = 1; ha = 1; hb = 1; b = ins[13:11];
    end else if (ins[18:16] == 3'b110) begin
      rwm = 2'b01; rw = 1; sc = 1; sz = 1; wc = 1; wz = 1; ha = 1;
    end else if (ins[18:15] == 4'b1110) begin
      br = 1;
      tk = (ins[14:13] == 2'b00) ? z : (ins[14:13] == 2'b01) ? !z :
           (ins[14:13] == 2'b10) ? c : !c;
    end
    st = (ha && (cyc - last_wr[ins[10:8]] <= 3)) || (hb && (cyc - last_wr[b] <= 3)) ||
         (br && (ins[14] ? (cyc - last_c == 1) : (cyc - last_z == 1)));
    if (st) begin
      mw = 0; rw = 0; wc = 0; wz = 0;
    end else if (br && tk) begin
      pm = 2'b01; fl = 1;
    end else if (ins[18:13] == 6'b111100) begin
      pm = 2'b10; fl = 1;
    end else if (ins[18:13] == 6'b111101) begin
      pm = 2'b10; pu = 1; fl = 1;
    end else if (ins[18:13] == 6'b111110) begin
      pm = 2'b11; po = 1; fl = 1;
    end
    e = {mw, rw, pu, po, uc, op, pm, rwm, ai, rb, sc, sz, wc, wz, st, fl};
    wr = rw; wrd = ins[13:11]; fc = wc; fz = wz;
    if (rst) begin
      e = '0; wr = 0; fc = 0; fz = 0;
    end
  endtask

  task automatic step(input string tag, input logic [18:0] ins, input logic c,
                      input logic z, input logic rst);
    logic [19:0] e;
    logic wr, fc, fz;
    logic [2:0] wrd;
    IF_ID_instruction = ins; C = c; Z = z; reset = rst;
    predict(ins, c, z, rst, e, wr, wrd, fc, fz);
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, {mem_write, reg_write, push, pop, alu_use_carry, alu_op, pc_mux, reg_write_mux,
                alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z, stall, flush},
          exp_q.pop_front());
    @(posedge clk);
    #1;
    if (rst) clear_model();
    else begin
      if (wr) last_wr[wrd] = cyc;
      if (fc) last_c = cyc;
      if (fz) last_z = cyc;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step("nop_gap", 19'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [18:0] add123, add415, add423, sub123, lw_r1, sw_r1, bz5, bnz5, bc5, and623;
  logic [18:0] jsb, jmp, ret, nop2, addc, addi, shf;

  initial begin
    clear_model();
    add123 = r_ins(2'b00, 3'b000, 3'd1, 3'd2, 3'd3);
    add415 = r_ins(2'b00, 3'b000, 3'd4, 3'd1, 3'd5);
    add423 = r_ins(2'b00, 3'b000, 3'd4, 3'd2, 3'd3);
    sub123 = r_ins(2'b00, 3'b010, 3'd1, 3'd2, 3'd3);
    and623 = r_ins(2'b00, 3'b100, 3'd6, 3'd2, 3'd3);
    addc   = r_ins(2'b00, 3'b001, 3'd7, 3'd6, 3'd5);
    addi   = {2'b01, 3'b110, 3'd5, 3'd2, 8'h3c};
    shf    = {3'b110, 2'b00, 3'd3, 3'd7, 8'h00};
    lw_r1  = {3'b100, 2'b00, 3'd1, 3'd2, 8'h10};
    sw_r1  = {3'b101, 2'b00, 3'd1, 3'd3, 8'h04};
    bz5    = {4'b1110, 2'b00, 5'd0, 8'd5};
    bnz5   = {4'b1110, 2'b01, 5'd0, 8'd5};
    bc5    = {4'b1110, 2'b10, 5'd0, 8'd5};
    jsb    = {6'b111101, 1'b0, 12'h123};
    jmp    = {6'b111100, 1'b0, 12'h0ab};
    ret    = {6'b111110, 13'd0};
    nop2   = {6'b111111, 13'd0};
    IF_ID_instruction = add123; C = 0; Z = 0; reset = 1;

    step("reset", add123, 0, 0, 1);
    step("reset", add123, 0, 0, 1);
    step("add_issue", add123, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("raw_stall", add415, 0, 0, 0);
    drain();
    step("indep_a", add123, 0, 0, 0);
    step("indep_b", add423, 0, 0, 0);
    drain();
    step("lw", lw_r1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("sw_raw", sw_r1, 0, 0, 0);
    drain();
    step("sub", sub123, 0, 1, 0);
    step("bz_taken", bz5, 0, 1, 0);
    step("bz_taken", bz5, 0, 1, 0);
    drain();
    step("sub", sub123, 0, 0, 0);
    step("bz_nt", bz5, 0, 0, 0);
    step("bz_nt", bz5, 0, 0, 0);
    drain();
    step("and", and623, 0, 0, 0);
    step("bc_nohaz", bc5, 1, 0, 0);
    step("bnz", bnz5, 0, 0, 0);
    drain();
    step("jsb", jsb, 0, 0, 0);
    step("ret", ret, 0, 0, 0);
    step("jmp", jmp, 0, 0, 0);
    step("nop0", 19'd0, 0, 0, 0);
    step("nop", nop2, 0, 0, 0);
    step("addc", addc, 1, 0, 0);
    step("addi", addi, 0, 0, 0);
    step("shift", shf, 0, 0, 0);
    drain();
    step("rst_pre", add123, 0, 0, 0);
    step("rst_stall", add415, 0, 0, 0);
    step("rst_mid", add415, 0, 0, 1);
    step("rst_after", add415, 0, 0, 0);
    step("rst_after2", add423, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
